// File: rtl/f_pc_reg.sv
// Fetch-stage PC register: latches decode npc, tracks delay-slot flag, flags AdEL on illegal fetch.
// Optional F_PC_FETCH_CNT_EN adds a 32-bit count of advancing (non-stalled) cycles on fetch_cnt.
module f_pc_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        D_is_jump,
  input  logic [31:0] F_instr_raw,
  output logic [31:0] F_pc,
  output logic        F_BD,
  output logic [31:0] F_instr,
  output logic        F_exc,
  output logic [4:0]  F_exc_code
`ifdef F_PC_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        en;

  // npc already carries HANDLER_PC on req; the value is kept only as documentation.
  logic handler_pc_unused;
  assign handler_pc_unused = ^HANDLER_PC;

  assign en = req | ~stall;

  always_comb begin
    pc_d = pc_q;
    bd_d = bd_q;
    if (en) begin
      pc_d = npc;
      bd_d = req ? 1'b0 : D_is_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign F_pc = pc_q;
  assign F_BD = bd_q;

  always_comb begin
    F_exc      = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q > IM_END);
    F_instr    = F_exc ? 32'h0 : F_instr_raw;
    F_exc_code = F_exc ? 5'd4 : 5'd0;
  end

`ifdef F_PC_FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_f_pc_reg.sv
// Bench for f_pc_reg: directed test-plan steps followed by randomized cycles vs a reference model.
module tb_f_pc_reg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_END   = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset, stall, req, D_is_jump;
  logic [31:0] npc, F_instr_raw;
  logic [31:0] F_pc, F_instr;
  logic        F_BD, F_exc;
  logic [4:0]  F_exc_code;
`ifdef F_PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_cnt;

  f_pc_reg dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .req(req),
    .D_is_jump(D_is_jump), .F_instr_raw(F_instr_raw),
    .F_pc(F_pc), .F_BD(F_BD), .F_instr(F_instr), .F_exc(F_exc),
    .F_exc_code(F_exc_code)
`ifdef F_PC_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= IM_BASE) && (a <= IM_END);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ex;
    ex = !legal(m_pc);
    check("F_pc", F_pc, m_pc);
    check("F_BD", {31'd0, F_BD}, {31'd0, m_bd});
    check("F_exc", {31'd0, F_exc}, {31'd0, ex});
    check("F_exc_code", {27'd0, F_exc_code}, ex ? 32'd4 : 32'd0);
    check("F_instr", F_instr, ex ? 32'd0 : F_instr_raw);
`ifdef F_PC_FETCH_CNT_EN
    check("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  task automatic step(input bit r, input logic [31:0] n, input bit s, input bit q, input bit j);
    reset = r; npc = n; stall = s; req = q; D_is_jump = j;
    F_instr_raw = $urandom;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_bd = 1'b0; m_cnt = 32'd0;
    end else if (q || !s) begin
      m_pc = n; m_bd = q ? 1'b0 : j; m_cnt = m_cnt + 32'd1;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] n;
    int k;
    m_pc = 32'hx; m_bd = 1'b0; m_cnt = 32'd0;
    reset = 1'b1; stall = 1'b0; req = 1'b0; D_is_jump = 1'b0;
    npc = 32'd0; F_instr_raw = 32'd0;
    step(1, 32'h0, 0, 0, 0);
    // sequential fetch
    step(0, m_pc + 32'd4, 0, 0, 0);
    step(0, m_pc + 32'd4, 0, 0, 0);
    check("seq_pc", F_pc, 32'h3008);
    // stall holds
    repeat (3) step(0, 32'h300c, 1, 0, 1);
    check("stall_hold", F_pc, 32'h3008);
    step(0, 32'h300c, 0, 0, 0);
    // req overrides stall, clears BD
    step(0, 32'h4180, 1, 1, 1);
    check("req_pc", F_pc, 32'h4180);
    check("req_bd", {31'd0, F_BD}, 32'd0);
    // delay slot
    step(0, 32'h3010, 0, 0, 1);
    check("bd_set", {31'd0, F_BD}, 32'd1);
    step(0, 32'h3014, 0, 0, 0);
    // address exceptions and boundaries
    step(0, 32'h3002, 0, 0, 0);
    check("misalign_code", {27'd0, F_exc_code}, 32'd4);
    step(0, 32'h2ffc, 0, 0, 0);
    step(0, 32'h7000, 0, 0, 0);
    step(0, 32'h6ffc, 0, 0, 0);
    check("end_legal", {31'd0, F_exc}, 32'd0);
    step(0, 32'h3000, 0, 0, 0);
    step(0, 32'hffff_fffc, 0, 0, 0);
    check("wrap_illegal", {31'd0, F_exc}, 32'd1);
    // exception persists while stalled
    step(0, 32'h3001, 0, 0, 1);
    repeat (2) step(0, 32'h3000, 1, 0, 0);
    check("exc_stall", {31'd0, F_exc}, 32'd1);
    // counter: 5 advancing + 2 stalled after reset
    step(1, 32'h0, 0, 0, 0);
    repeat (5) step(0, m_pc + 32'd4, 0, 0, 0);
    repeat (2) step(0, 32'h3100, 1, 0, 0);
`ifdef F_PC_FETCH_CNT_EN
    check("cnt5", fetch_cnt, 32'd5);
`endif
    step(1, 32'h5000, 0, 1, 1);
    check("midrun_reset", F_pc, 32'h3000);
    // randomized phase
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       n = $urandom;
        1:       n = IM_BASE - 32'd4;
        2:       n = IM_END;
        3:       n = IM_END + 32'd4;
        4:       n = 32'h4180;
        default: n = legal(m_pc) ? m_pc + 32'd4 : IM_BASE + ($urandom_range(0, 16383) << 2) % 32'h4000;
      endcase
      step($urandom_range(0, 49) == 0, n, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/f_pc_reg.md
Name: f_pc_reg

Overview:
- Fetch-stage PC register; consumer end of the D-stage next-PC interface.
- Latches the decode-stage npc each advancing cycle and presents F_pc to instruction memory.
- Tracks the branch-delay-slot flag of the instruction being fetched.
- Raises fetch address exceptions (AdEL) and nullifies the fetched word when the fetch address is illegal.

Parameters:
- RESET_PC, 32'h0000_3000, F_pc value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry; npc carries this value when req is high.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_END, 32'h0000_6ffc, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- npc  in  32  next PC from the decode-stage next-PC logic.
- stall  in  1  hazard stall; holds F_pc and F_BD.
- req  in  1  exception/interrupt taken this cycle; overrides stall.
- D_is_jump  in  1  decode instruction is a branch/jump (Br != pc4 class); the next fetched word is a delay slot.
- F_instr_raw  in  32  word read from instruction memory at F_pc.
- F_pc  out  32  current fetch address (register).
- F_BD  out  1  fetched instruction is in a delay slot (register).
- F_instr  out  32  F_instr_raw, or 32'h0 (nop) when F_exc=1.
- F_exc  out  1  fetch address exception.
- F_exc_code  out  5  5'd4 (AdEL) when F_exc=1, else 5'd0.

Behaviour:
- Reset (synchronous, clk edge with reset=1): F_pc<=RESET_PC, F_BD<=0. Therefore F_exc=0, F_exc_code=0, F_instr=F_instr_raw. Reset dominates req and stall.
- Update enable: en = req | ~stall.
- en=1:
  - F_pc<=npc (no local arithmetic; npc already selects pc+4, jump, reg, branch, EPC or HANDLER_PC).
  - F_BD<= req ? 0 : D_is_jump.
- en=0 (stall=1, req=0): F_pc and F_BD hold.
- Latency: npc presented in cycle N appears on F_pc in cycle N+1. Exception outputs are combinational from F_pc, so they are valid in the same cycle as the F_pc they describe.
- Simultaneous stall=1 and req=1: update occurs and F_BD clears. The handler's first instruction is never a delay slot.
- req with npc != HANDLER_PC: F_pc loads npc regardless. The block does not check consistency.
- Exception detection:
  - F_exc = (F_pc[1:0] != 2'b00) | (F_pc < IM_BASE) | (F_pc > IM_END).
  - Comparisons are unsigned 32-bit.
  - Exactly IM_BASE and exactly IM_END are legal.
  - 32'hffff_fffc is illegal; wrap-around is not treated as in range.
- F_exc=1: F_instr=32'h0 and F_exc_code=5'd4. F_BD is still reported so a later stage can compute EPC correctly.
- Stall while F_exc=1: F_exc stays asserted, because it is derived from the held F_pc.
- No internal state beyond F_pc, F_BD and the optional counter.

Optional Feature:
- Macro: F_PC_FETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt (32 bits).
  - Reset to 0.
  - Increments by 1 on every cycle with en=1 and reset=0.
  - Wraps 32'hffff_ffff -> 0.
  - Not incremented on stalled cycles.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then npc=F_pc+4 each cycle -> F_pc sequence 0x3000, 0x3004, 0x3008; F_BD=0; F_exc=0.
- F_pc=0x3008, stall=1 for 3 cycles with npc=0x300c -> F_pc holds 0x3008; F_BD holds. Stall=0 -> F_pc=0x300c next cycle.
- stall=1, req=1, npc=0x4180, D_is_jump=1 -> next cycle F_pc=0x4180 and F_BD=0.
- D_is_jump=1, npc=0x3010, stall=0 -> next cycle F_pc=0x3010 and F_BD=1. Following cycle with D_is_jump=0 -> F_BD=0.
- npc=0x3002 -> F_exc=1, F_exc_code=4, F_instr=0. npc=0x2ffc and npc=0x7000 -> F_exc=1. npc=0x6ffc -> F_exc=0, F_instr=F_instr_raw.
- F_PC_FETCH_CNT_EN defined: 5 advancing cycles plus 2 stalled cycles after reset -> fetch_cnt=5. Reset asserted mid-run -> fetch_cnt=0 and F_pc=0x3000 next cycle.
